// File: rtl/alu_rf_mp_if.sv
// Bus bundle for the multi-read-port register file: write path, read path,
// bulk-clear control and the clear-FSM state for observation.
//
// Handshake: there is no back-pressure. A write (we) is taken at any rising
// edge while the clear engine is idle. A read (rd_en) is taken at every edge;
// rValid high means rData holds the answer to the request taken at the
// previous edge. clr_req is a one-cycle pulse, and clr_busy stays high while
// the clear engine runs.
interface alu_rf_mp_if #(
   parameter int DW  = 32,
   parameter int AW  = 4,
   parameter int NRD = 3
);
   logic                we;
   logic [AW-1:0]       wAddr;
   logic [DW-1:0]       wData;
   logic [DW/8-1:0]     wBe;
   logic                rd_en;
   logic [NRD*AW-1:0]   rAddr;
   logic [NRD*DW-1:0]   rData;
   logic                rValid;
   logic                clr_req;
   logic                clr_busy;
   logic                clr_state;  // 0 = IDLE, 1 = CLEAR

   modport master (
      output we, wAddr, wData, wBe, rd_en, rAddr, clr_req,
      input  rData, rValid, clr_busy, clr_state
   );

   modport slave (
      input  we, wAddr, wData, wBe, rd_en, rAddr, clr_req,
      output rData, rValid, clr_busy, clr_state
   );
endinterface

// File: rtl/alu_rf_mp.sv
// Parametrised register file with NRD registered read ports. It supports
// byte-enable writes, and a read sees a write made on the same edge to the
// same address. A sequential engine clears the whole array, one entry per
// cycle.
module alu_rf_mp #(
   parameter int DW  = 32,
   parameter int AW  = 4,
   parameter int NRD = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   alu_rf_mp_if.slave    bus
);
   localparam int            DEPTH = 1 << AW;
   localparam int            NBE   = DW / 8;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     mem_q [DEPTH];
   logic [DW-1:0]     mem_d [DEPTH];
   logic [NRD*DW-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   logic              wr_fire;
   logic [DW-1:0]     wr_merged;
   logic [AW-1:0]     ra;

   // Writes are only honoured while idle; during a clear they are dropped.
   assign wr_fire = bus.we && (state_q == IDLE);

   // Merge new write bytes over the current contents of the target word.
   always_comb begin
      wr_merged = mem_q[bus.wAddr];
      for (int b = 0; b < NBE; b++) begin
         if (bus.wBe[b]) wr_merged[8*b +: 8] = bus.wData[8*b +: 8];
      end
   end

   // Clear FSM: start on clr_req, then walk cnt from 0 to DEPTH-1 and return to idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Array update: the clear engine owns the array while active, otherwise the write port does.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) mem_d[k] = mem_q[k];
      if (state_q == CLEAR) begin
         mem_d[cnt_q] = '0;
      end else if (wr_fire) begin
         mem_d[bus.wAddr] = wr_merged;
      end
   end

   // Read ports: bypass a same-edge write. During a clear, reads return 0 because the array is treated as already empty.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = bus.rd_en;
      ra       = '0;
      if (bus.rd_en) begin
         for (int i = 0; i < NRD; i++) begin
            ra = bus.rAddr[i*AW +: AW];
            if (state_q == CLEAR) begin
               rdata_d[i*DW +: DW] = '0;
            end else if (wr_fire && (ra == bus.wAddr)) begin
               rdata_d[i*DW +: DW] = wr_merged;
            end else begin
               rdata_d[i*DW +: DW] = mem_q[ra];
            end
         end
      end
   end

   // State registers; reset clears the array, read outputs and clear engine at once.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
      end
   end

   assign bus.rData     = rdata_q;
   assign bus.rValid    = rvalid_q;
   assign bus.clr_busy  = (state_q == CLEAR);
   assign bus.clr_state = state_q;

endmodule

// File: tb/tb_alu_rf_mp.sv
// Directed bench for alu_rf_mp: reset, full and byte writes, bypass,
// boundary addresses, bulk clear, and reset during a clear.
module tb_alu_rf_mp;
   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int NRD = 3;

   logic clk;
   logic reset_n;

   int n_checks;
   int n_pass;
   int busy_cycles;

   logic [DW-1:0] exp_q[$];

   alu_rf_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

   alu_rf_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.we      = 1'b0;
      bus.wAddr   = '0;
      bus.wData   = '0;
      bus.wBe     = '0;
      bus.rd_en   = 1'b0;
      bus.rAddr   = '0;
      bus.clr_req = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
      bus.we    = 1'b1;
      bus.wAddr = a;
      bus.wData = d;
      bus.wBe   = be;
      tick();
      bus.we    = 1'b0;
      bus.wBe   = '0;
   endtask

   // Compare the three read ports and rValid against the oldest expected entries.
   task automatic score(input string tag);
      logic [DW-1:0] e;
      for (int i = 0; i < NRD; i++) begin
         e = exp_q.pop_front();
         check_eq($sformatf("%s_p%0d", tag, i), bus.rData[i*DW +: DW], e);
      end
      check_eq({tag, "_valid"}, 32'(bus.rValid), 32'd1);
   endtask

   // Issue one read on all ports and check the answer one cycle later.
   task automatic do_read(input string tag,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      bus.rd_en = 1'b1;
      bus.rAddr = {a2, a1, a0};
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      tick();
      bus.rd_en = 1'b0;
      score(tag);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      idle_inputs();

      // 1: reset, with a read request pending that must not produce rValid
      reset_n   = 1'b0;
      bus.rd_en = 1'b1;
      bus.rAddr = {4'd2, 4'd1, 4'd0};
      tick();
      tick();
      check_eq("rst_valid", 32'(bus.rValid), 32'd0);
      check_eq("rst_rdata0", bus.rData[0 +: DW], 32'd0);
      check_eq("rst_rdata1", bus.rData[DW +: DW], 32'd0);
      check_eq("rst_rdata2", bus.rData[2*DW +: DW], 32'd0);
      check_eq("rst_busy", 32'(bus.clr_busy), 32'd0);
      check_eq("rst_state", 32'(bus.clr_state), 32'd0);
      bus.rd_en = 1'b0;
      reset_n   = 1'b1;
      for (int a = 0; a < 16; a++) begin
         do_read($sformatf("rst_rd%0d", a), AW'(a), AW'(15 - a), AW'(a), 32'd0, 32'd0, 32'd0);
      end

      // 2: full-word write and read back
      do_write(4'd5, 32'hDEADBEEF, 4'hF);
      do_read("full_wr", 4'd5, 4'd0, 4'd0, 32'hDEADBEEF, 32'd0, 32'd0);
      tick();
      check_eq("idle_valid", 32'(bus.rValid), 32'd0);
      check_eq("idle_hold", bus.rData[0 +: DW], 32'hDEADBEEF);

      // 3: byte-enable write touches bytes 0 and 2 only
      do_write(4'd5, 32'h11223344, 4'b0101);
      do_read("be_wr", 4'd5, 4'd5, 4'd0, 32'hDE22BE44, 32'hDE22BE44, 32'd0);

      // Write with no byte enables leaves the word unchanged
      do_write(4'd5, 32'hFFFFFFFF, 4'h0);
      do_read("be_none", 4'd5, 4'd1, 4'd5, 32'hDE22BE44, 32'd0, 32'hDE22BE44);

      // 4: bypass on ports 0 and 2, port 1 reads the old value at address 5
      bus.we    = 1'b1;
      bus.wAddr = 4'd3;
      bus.wData = 32'hA5A5A5A5;
      bus.wBe   = 4'hF;
      do_read("bypass", 4'd3, 4'd5, 4'd3, 32'hA5A5A5A5, 32'hDE22BE44, 32'hA5A5A5A5);
      bus.we = 1'b0;
      do_read("bypass_st", 4'd3, 4'd3, 4'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

      // Partial-byte bypass returns the merged word
      bus.we    = 1'b1;
      bus.wAddr = 4'd3;
      bus.wData = 32'h00000000;
      bus.wBe   = 4'b0011;
      do_read("bypass_be", 4'd3, 4'd0, 4'd3, 32'hA5A50000, 32'd0, 32'hA5A50000);
      bus.we = 1'b0;

      // Boundary addresses 0 and 15
      do_write(4'd15, 32'hCAFEF00D, 4'hF);
      do_write(4'd0, 32'h0BADBEEF, 4'hF);
      do_read("edge_addr", 4'd15, 4'd0, 4'd15, 32'hCAFEF00D, 32'h0BADBEEF, 32'hCAFEF00D);

      // 5: bulk clear; load reg[i] = i+1 first
      for (int i = 0; i < 16; i++) do_write(AW'(i), 32'(i + 1), 4'hF);
      // clr_req, write and read on the same idle edge: the read sees the bypassed write
      bus.clr_req = 1'b1;
      bus.we      = 1'b1;
      bus.wAddr   = 4'd2;
      bus.wData   = 32'hABCD0000;
      bus.wBe     = 4'hF;
      do_read("clr_same_edge", 4'd2, 4'd4, 4'd2, 32'hABCD0000, 32'd5, 32'hABCD0000);
      busy_cycles = bus.clr_busy ? 1 : 0;
      check_eq("clr_state", 32'(bus.clr_state), 32'd1);
      // Keep writing to address 7 for the whole clear; all of these writes must be dropped
      bus.clr_req = 1'b0;
      bus.wAddr   = 4'd7;
      bus.wData   = 32'hFFFFFFFF;
      do_read("clr_rd", 4'd15, 4'd2, 4'd7, 32'd0, 32'd0, 32'd0);
      if (bus.clr_busy) busy_cycles++;
      for (int g = 0; g < 40 && bus.clr_busy; g++) begin
         tick();
         if (bus.clr_busy) busy_cycles++;
      end
      bus.we = 1'b0;
      check_eq("clr_busy_len", 32'(busy_cycles), 32'd16);
      check_eq("clr_busy_end", 32'(bus.clr_busy), 32'd0);
      for (int a = 0; a < 16; a++) begin
         do_read($sformatf("clr_rd%0d", a), AW'(a), 4'd7, AW'(15 - a), 32'd0, 32'd0, 32'd0);
      end

      // 6: reset partway through a clear; address 9 has not been cleared yet at that point
      do_write(4'd9, 32'h99999999, 4'hF);
      do_write(4'd4, 32'h44444444, 4'hF);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      check_eq("mid_clr_busy", 32'(bus.clr_busy), 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_eq("mid_rst_busy", 32'(bus.clr_busy), 32'd0);
      check_eq("mid_rst_state", 32'(bus.clr_state), 32'd0);
      check_eq("mid_rst_valid", 32'(bus.rValid), 32'd0);
      for (int a = 0; a < 16; a++) begin
         do_read($sformatf("mid_rst_rd%0d", a), AW'(a), 4'd9, 4'd4, 32'd0, 32'd0, 32'd0);
      end
      do_write(4'd9, 32'h12345678, 4'hF);
      do_read("post_rst_wr", 4'd9, 4'd8, 4'd9, 32'h12345678, 32'd0, 32'h12345678);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
